// File: rtl/pcs_sync_ctrl.sv
// -----------------------------------------------------------------------------
// pcs_sync_ctrl
//   1000BASE-X PCS receive synchronization controller. Sits between the 10b
//   code-group deserializer/decoder and the PCS receive FSM, acquires and
//   monitors code-group alignment, tracks even/odd position and qualifies
//   code-groups to the receive FSM only while synchronized.
//
// Parameters
//   GOOD_CGS_MAX  consecutive good code-groups needed to step back one
//                 SYNC_ACQUIRED level
//   CNT_W         width of the saturating loss-of-sync counter
//
// Ports
//   GTX_CLK        in   receive clock, one code-group per rising edge
//   mr_main_reset  in   asynchronous active-low reset
//   rx_code_group  in   10b code-group, bit9 = 'a' ... bit0 = 'j'
//   cg_valid       in   group is in the 8b/10b table for current disparity
//   cg_is_data     in   group is a valid Dx.y
//   signal_detect  in   PMD signal present; 0 forces loss of sync
//   sync_status    out  1 = synchronized
//   rx_even        out  1 = last accepted code-group was at an even position
//   rx_cg_out      out  registered copy of rx_code_group
//   rx_cg_out_vld  out  rx_cg_out is qualified for the receive FSM
//   sync_loss_cnt  out  saturating count of SYNC_ACQUIRED_* -> LOSS_OF_SYNC
// -----------------------------------------------------------------------------
module pcs_sync_ctrl #(
   parameter int GOOD_CGS_MAX = 3,
   parameter int CNT_W        = 8
) (
   input  logic             GTX_CLK,
   input  logic             mr_main_reset,
   input  logic [9:0]       rx_code_group,
   input  logic             cg_valid,
   input  logic             cg_is_data,
   input  logic             signal_detect,
   output logic             sync_status,
   output logic             rx_even,
   output logic [9:0]       rx_cg_out,
   output logic             rx_cg_out_vld,
   output logic [CNT_W-1:0] sync_loss_cnt
);

   typedef enum logic [3:0] {
      LOSS_OF_SYNC,
      COMMA_DETECT_1,
      ACQUIRE_SYNC_1,
      COMMA_DETECT_2,
      ACQUIRE_SYNC_2,
      COMMA_DETECT_3,
      SYNC_ACQUIRED_1,
      SYNC_ACQUIRED_2,
      SYNC_ACQUIRED_2A,
      SYNC_ACQUIRED_3,
      SYNC_ACQUIRED_3A,
      SYNC_ACQUIRED_4,
      SYNC_ACQUIRED_4A
   } state_t;

   function automatic logic is_sync(input state_t s);
      return s inside {SYNC_ACQUIRED_1, SYNC_ACQUIRED_2, SYNC_ACQUIRED_2A,
                       SYNC_ACQUIRED_3, SYNC_ACQUIRED_3A,
                       SYNC_ACQUIRED_4, SYNC_ACQUIRED_4A};
   endfunction

   state_t     state, next_state;
   logic [1:0] good_cgs, next_good;
   logic [1:0] good_inc;
   logic [6:0] cg_hi;
   logic       comma, cgbad, cggood;
   logic       next_even;
   logic       loss_event;

   // Comma detection covers both running-disparity forms of the 7-bit comma.
   assign cg_hi  = rx_code_group[9:3];
   assign comma  = (cg_hi == 7'b0011111) || (cg_hi == 7'b1100000);
   // rx_even=1 means the current group sits at an odd position, so a comma
   // arriving now is misaligned.
   assign cgbad  = !cg_valid || (comma && rx_even);
   assign cggood = !cgbad;

   // The good group that moves SYNC_ACQUIRED_n into _nA is the first of the
   // run; good_cgs then counts the further ones, so the step back happens on
   // the good group that brings the incremented count to GOOD_CGS_MAX-1.
   assign good_inc = good_cgs + 2'd1;

   // NOTE: every combinational output gets a default first so no path through
   // the case statement leaves a value unassigned and infers a latch.
   always_comb begin
      next_state = state;
      next_good  = '0;
      if (!signal_detect) begin
         next_state = LOSS_OF_SYNC;
      end else begin
         unique case (state)
            LOSS_OF_SYNC:
               if (comma && cg_valid) next_state = COMMA_DETECT_1;
            COMMA_DETECT_1:
               next_state = cg_is_data ? ACQUIRE_SYNC_1 : LOSS_OF_SYNC;
            COMMA_DETECT_2:
               next_state = cg_is_data ? ACQUIRE_SYNC_2 : LOSS_OF_SYNC;
            COMMA_DETECT_3:
               next_state = cg_is_data ? SYNC_ACQUIRED_1 : LOSS_OF_SYNC;
            ACQUIRE_SYNC_1:
               if (!rx_even && comma && cg_valid) next_state = COMMA_DETECT_2;
               else if (cgbad)                    next_state = LOSS_OF_SYNC;
            ACQUIRE_SYNC_2:
               if (!rx_even && comma && cg_valid) next_state = COMMA_DETECT_3;
               else if (cgbad)                    next_state = LOSS_OF_SYNC;
            SYNC_ACQUIRED_1:
               if (cgbad) next_state = SYNC_ACQUIRED_2;
            SYNC_ACQUIRED_2:
               next_state = cgbad ? SYNC_ACQUIRED_3 : SYNC_ACQUIRED_2A;
            SYNC_ACQUIRED_3:
               next_state = cgbad ? SYNC_ACQUIRED_4 : SYNC_ACQUIRED_3A;
            SYNC_ACQUIRED_4:
               next_state = cgbad ? LOSS_OF_SYNC : SYNC_ACQUIRED_4A;
            SYNC_ACQUIRED_2A:
               if (cgbad)                                next_state = SYNC_ACQUIRED_3;
               else if (good_inc == 2'(GOOD_CGS_MAX - 1)) next_state = SYNC_ACQUIRED_1;
               else                                      next_good  = good_inc;
            SYNC_ACQUIRED_3A:
               if (cgbad)                                next_state = SYNC_ACQUIRED_4;
               else if (good_inc == 2'(GOOD_CGS_MAX - 1)) next_state = SYNC_ACQUIRED_2;
               else                                      next_good  = good_inc;
            SYNC_ACQUIRED_4A:
               if (cgbad)                                next_state = LOSS_OF_SYNC;
               else if (good_inc == 2'(GOOD_CGS_MAX - 1)) next_state = SYNC_ACQUIRED_3;
               else                                      next_good  = good_inc;
            default:
               next_state = LOSS_OF_SYNC;
         endcase
      end
   end

   // Entering a COMMA_DETECT state realigns parity; every other cycle flips it.
   assign next_even  = (next_state inside {COMMA_DETECT_1, COMMA_DETECT_2, COMMA_DETECT_3})
                       ? 1'b1 : !rx_even;
   assign loss_event = is_sync(state) && (next_state == LOSS_OF_SYNC);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge GTX_CLK or negedge mr_main_reset) begin
      if (!mr_main_reset) begin
         state         <= LOSS_OF_SYNC;
         good_cgs      <= '0;
         sync_status   <= 1'b0;
         rx_even       <= 1'b0;
         rx_cg_out     <= '0;
         rx_cg_out_vld <= 1'b0;
         sync_loss_cnt <= '0;
      end else begin
         state         <= next_state;
         good_cgs      <= next_good;
         sync_status   <= is_sync(next_state);
         rx_even       <= next_even;
         rx_cg_out     <= rx_code_group;
         rx_cg_out_vld <= is_sync(next_state);
         if (loss_event && !(&sync_loss_cnt))
            sync_loss_cnt <= sync_loss_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_pcs_sync_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pcs_sync_ctrl
//   Self-checking bench for pcs_sync_ctrl. A table of hand-derived vectors
//   walks acquisition, level step-back, loss via spaced errors, odd-position
//   commas and acquisition aborts; hand-written sequences cover repeated
//   signal_detect drops up to counter saturation and an asynchronous reset in
//   the middle of ACQUIRE_SYNC_2. Expected results are pushed to a scoreboard
//   queue when a vector is driven and popped when the registered outputs
//   appear one edge later.
// -----------------------------------------------------------------------------
module tb_pcs_sync_ctrl;

   localparam int         CNT_W = 8;
   localparam logic [9:0] K_M   = 10'b0011111010;  // K28.5, RD-
   localparam logic [9:0] K_P   = 10'b1100000101;  // K28.5, RD+
   localparam logic [9:0] D16_2 = 10'b0110110101;
   localparam logic [9:0] D21_5 = 10'b1010101010;

   typedef struct {
      logic [9:0]       cg;
      logic             v;
      logic             d;
      logic             sd;
      logic             e_sync;
      logic             e_even;
      logic [CNT_W-1:0] e_cnt;
   } vec_t;

   logic             GTX_CLK = 1'b0;
   logic             mr_main_reset = 1'b0;
   logic [9:0]       rx_code_group = '0;
   logic             cg_valid = 1'b0;
   logic             cg_is_data = 1'b0;
   logic             signal_detect = 1'b1;
   logic             sync_status;
   logic             rx_even;
   logic [9:0]       rx_cg_out;
   logic             rx_cg_out_vld;
   logic [CNT_W-1:0] sync_loss_cnt;

   int               total = 0;
   int               bad   = 0;
   vec_t             sb_q[$];
   vec_t             tbl[$];
   logic [CNT_W-1:0] exp_cnt;

   pcs_sync_ctrl #(.GOOD_CGS_MAX(3), .CNT_W(CNT_W)) dut (
      .GTX_CLK       (GTX_CLK),
      .mr_main_reset (mr_main_reset),
      .rx_code_group (rx_code_group),
      .cg_valid      (cg_valid),
      .cg_is_data    (cg_is_data),
      .signal_detect (signal_detect),
      .sync_status   (sync_status),
      .rx_even       (rx_even),
      .rx_cg_out     (rx_cg_out),
      .rx_cg_out_vld (rx_cg_out_vld),
      .sync_loss_cnt (sync_loss_cnt)
   );

   always #5 GTX_CLK = ~GTX_CLK;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic vec_t mk(input logic [9:0] cg, input logic v, input logic d,
                               input logic sd, input logic es, input logic ee,
                               input logic [CNT_W-1:0] ec);
      vec_t r;
      r.cg = cg; r.v = v; r.d = d; r.sd = sd;
      r.e_sync = es; r.e_even = ee; r.e_cnt = ec;
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Drive one vector (called just after a falling edge), queue its
   // expectation, then compare at the following falling edge.
   task automatic apply(input vec_t v, input string tag);
      vec_t e;
      rx_code_group = v.cg;
      cg_valid      = v.v;
      cg_is_data    = v.d;
      signal_detect = v.sd;
      sb_q.push_back(v);
      @(posedge GTX_CLK);
      @(negedge GTX_CLK);
      if (sb_q.size() == 0) begin
         total++;
         bad++;
         $display("FAIL %s.scoreboard: queue empty", tag);
      end else begin
         e = sb_q.pop_front();
         check({tag, ".sync"},  32'(sync_status),   32'(e.e_sync));
         check({tag, ".vld"},   32'(rx_cg_out_vld), 32'(e.e_sync));
         check({tag, ".even"},  32'(rx_even),       32'(e.e_even));
         check({tag, ".cg"},    32'(rx_cg_out),     32'(e.cg));
         check({tag, ".cnt"},   32'(sync_loss_cnt), 32'(e.e_cnt));
      end
   endtask

   // K/D x3 acquisition from LOSS_OF_SYNC; parity is forced by COMMA_DETECT_1
   // so the expected trace does not depend on the starting parity.
   task automatic acquire(input logic [CNT_W-1:0] cnt, input int steps, input string tag);
      vec_t seq[6];
      seq[0] = mk(K_M,   1'b1, 1'b0, 1'b1, 1'b0, 1'b1, cnt);
      seq[1] = mk(D16_2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, cnt);
      seq[2] = mk(K_P,   1'b1, 1'b0, 1'b1, 1'b0, 1'b1, cnt);
      seq[3] = mk(D16_2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, cnt);
      seq[4] = mk(K_M,   1'b1, 1'b0, 1'b1, 1'b0, 1'b1, cnt);
      seq[5] = mk(D16_2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, cnt);
      for (int i = 0; i < steps; i++) apply(seq[i], $sformatf("%s.%0d", tag, i));
   endtask

   initial begin
      //          cg     valid data  sd    sync  even  cnt
      // acquisition: three comma/data pairs
      tbl.push_back(mk(K_M,   1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'd0));  // CD1
      tbl.push_back(mk(D16_2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0));  // AS1
      tbl.push_back(mk(K_P,   1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'd0));  // CD2
      tbl.push_back(mk(D16_2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0));  // AS2
      tbl.push_back(mk(K_M,   1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'd0));  // CD3
      tbl.push_back(mk(D16_2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0));  // SA1
      // one invalid group, then three good groups back to SA1
      tbl.push_back(mk(D16_2, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'd0));  // SA2
      tbl.push_back(mk(D16_2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0));  // SA2A
      tbl.push_back(mk(D21_5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'd0));  // SA2A
      tbl.push_back(mk(D16_2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0));  // SA1
      // four bad groups spaced by single good groups -> loss
      tbl.push_back(mk(D16_2, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'd0));  // SA2
      tbl.push_back(mk(D21_5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0));  // SA2A
      tbl.push_back(mk(D16_2, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'd0));  // SA3
      tbl.push_back(mk(D16_2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0));  // SA3A
      tbl.push_back(mk(D16_2, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'd0));  // SA4
      tbl.push_back(mk(D21_5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0));  // SA4A
      tbl.push_back(mk(D16_2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'd1));  // LOSS
      // re-acquire, then an odd-position comma counts as a bad group
      tbl.push_back(mk(K_M,   1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'd1));  // CD1
      tbl.push_back(mk(D16_2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1));  // AS1
      tbl.push_back(mk(K_P,   1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'd1));  // CD2
      tbl.push_back(mk(D16_2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1));  // AS2
      tbl.push_back(mk(K_M,   1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'd1));  // CD3
      tbl.push_back(mk(D16_2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'd1));  // SA1
      tbl.push_back(mk(K_M,   1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'd1));  // even comma: SA1
      tbl.push_back(mk(K_P,   1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd1));  // odd comma: SA2
      // three more spaced errors lose sync only if the odd comma counted
      tbl.push_back(mk(D16_2, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'd1));  // SA3
      tbl.push_back(mk(D16_2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'd1));  // SA3A
      tbl.push_back(mk(D16_2, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'd1));  // SA4
      tbl.push_back(mk(D16_2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'd1));  // SA4A
      tbl.push_back(mk(D16_2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'd2));  // LOSS
      // acquisition aborts: odd comma in AS1, non-data after CD1
      tbl.push_back(mk(K_M,   1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'd2));  // CD1
      tbl.push_back(mk(D16_2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd2));  // AS1
      tbl.push_back(mk(D21_5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'd2));  // AS1 hold
      tbl.push_back(mk(K_M,   1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd2));  // LOSS
      tbl.push_back(mk(K_P,   1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'd2));  // CD1
      tbl.push_back(mk(K_M,   1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd2));  // LOSS
      // signal_detect low blocks comma detection in LOSS_OF_SYNC
      tbl.push_back(mk(K_M,   1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd2));  // LOSS

      // Reset values while reset is held.
      #12;
      check("reset.sync", 32'(sync_status),   32'd0);
      check("reset.even", 32'(rx_even),       32'd0);
      check("reset.cg",   32'(rx_cg_out),     32'd0);
      check("reset.vld",  32'(rx_cg_out_vld), 32'd0);
      check("reset.cnt",  32'(sync_loss_cnt), 32'd0);
      #1 mr_main_reset = 1'b1;
      @(negedge GTX_CLK);

      foreach (tbl[i]) apply(tbl[i], $sformatf("tbl[%0d]", i));

      // Repeated signal_detect drops from SYNC_ACQUIRED_1 until saturation.
      exp_cnt = 8'd2;
      for (int i = 0; i < (1 << CNT_W) + 3; i++) begin
         acquire(exp_cnt, 6, $sformatf("acq%0d", i));
         exp_cnt = (exp_cnt == 8'hFF) ? 8'hFF : exp_cnt + 8'd1;
         apply(mk(D16_2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, exp_cnt), $sformatf("drop%0d", i));
      end
      check("cnt_saturated", 32'(sync_loss_cnt), 32'hFF);

      // Asynchronous reset in the middle of ACQUIRE_SYNC_2.
      acquire(exp_cnt, 4, "pre_rst");
      #1 mr_main_reset = 1'b0;
      #1;
      check("midrst.sync", 32'(sync_status),   32'd0);
      check("midrst.even", 32'(rx_even),       32'd0);
      check("midrst.cg",   32'(rx_cg_out),     32'd0);
      check("midrst.vld",  32'(rx_cg_out_vld), 32'd0);
      check("midrst.cnt",  32'(sync_loss_cnt), 32'd0);
      #1 mr_main_reset = 1'b1;
      // Sync must wait for the full three-comma sequence again.
      acquire(8'd0, 6, "reacq");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
